// File: rtl/rx_arbiter.sv
// Round-robin arbiter merging NREQ valid/ready requesters onto one receiver.
// Grants hold for up to BURST_MAX beats, with a one-cycle arbitration bubble.
module rx_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 32,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               out_valid,
   output logic [DW-1:0]      out_data,
   input  logic               out_ready,
   output logic [NREQ-1:0]    grant,
   output logic               busy
);

   localparam int unsigned      PW       = $clog2(NREQ);
   localparam int unsigned      BW       = $clog2(BURST_MAX + 1);
   localparam logic [BW-1:0]    BeatLast = BW'(BURST_MAX - 1);
   localparam logic [PW-1:0]    PtrInit  = PW'(NREQ - 1);
   localparam logic [NREQ-1:0]  GrantOne = NREQ'(1);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e          state_q;
   logic [NREQ-1:0] grant_q;
   logic [BW-1:0]   beat_q;
   logic [PW-1:0]   last_q;

   logic            hi_found, lo_found, sel_found;
   logic [PW-1:0]   hi_idx, lo_idx, sel_idx;
   logic [PW-1:0]   g_idx;
   logic [DW-1:0]   g_data;
   logic            g_valid;

   // Lowest valid index above last_q wins; otherwise wrap to the lowest valid index.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (i > int'(last_q)) begin
               hi_found = 1'b1;
               hi_idx   = PW'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = PW'(i);
            end
         end
      end
      sel_found = hi_found | lo_found;
      sel_idx   = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_q[i]) begin
            g_idx  = PW'(i);
            g_data = req_data[i*DW +: DW];
         end
      end
   end

   assign g_valid   = |(req_valid & grant_q);
   assign busy      = (state_q == StGrant);
   assign grant     = grant_q;
   assign out_valid = busy & g_valid;
   assign out_data  = busy ? g_data : '0;
   // Ready follows the receiver only; it never looks at the requester's own valid.
   assign req_ready = busy ? (grant_q & {NREQ{out_ready}}) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         beat_q  <= '0;
         last_q  <= PtrInit;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sel_found) begin
                  grant_q <= GrantOne << sel_idx;
                  beat_q  <= '0;
                  state_q <= StGrant;
               end else begin
                  grant_q <= '0;
               end
            end
            StGrant: begin
               if (!g_valid) begin
                  state_q <= StIdle;
                  last_q  <= g_idx;
                  grant_q <= '0;
               end else if (out_ready) begin
                  beat_q <= beat_q + BW'(1);
                  if (beat_q == BeatLast) begin
                     state_q <= StIdle;
                     last_q  <= g_idx;
                     grant_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_arbiter.sv
// Directed bench for rx_arbiter: rotation, bursts, stalls, wrap-around and reset.
module tb_rx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic               out_ready;
   logic [NREQ-1:0]    grant;
   logic               busy;

   int checks = 0;
   int errors = 0;

   rx_arbiter #(
      .NREQ      (NREQ),
      .DW        (DW),
      .BURST_MAX (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_req_ready"}, req_ready, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst");
      @(posedge clk);
      #1;
      chk("rst_hold_grant", grant, 0);
      rst_n = 1'b1;
   endtask

   task automatic set_data();
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hD000_0000 | i;
   endtask

   // Ready must be one-hot-or-zero, and exactly one-hot on any transfer.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("ready_onehot0", $onehot0(req_ready), 1);
         if (out_valid && out_ready) chk("ready_onehot_xfer", $onehot(req_ready), 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      req_data  = '0;
      req_valid = 4'b1111;

      // Full rotation with every requester valid
      set_data();
      out_ready = 1'b1;
      do_reset();
      for (int g = 0; g < NREQ; g++) begin
         for (int b = 0; b < 4; b++) begin
            tick();
            chk("rr_grant", grant, 4'b0001 << g);
            chk("rr_data", out_data, 32'hD000_0000 | g);
            chk("rr_ready", req_ready, 4'b0001 << g);
         end
         tick();
         chk("rr_bubble_grant", grant, 0);
         chk("rr_bubble_busy", busy, 0);
      end
      tick();
      chk("rr_wrap", grant, 4'b0001);

      // Short packet from requester 2, then early release
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b0100;
      req_data[2*DW +: DW] = 32'h0000_00A0;
      tick();
      chk("pkt_grant", grant, 4'b0100);
      chk("pkt_a0", out_data, 32'h0000_00A0);
      tick();
      req_data[2*DW +: DW] = 32'h0000_00A1;
      settle();
      chk("pkt_a1", out_data, 32'h0000_00A1);
      tick();
      req_data[2*DW +: DW] = 32'h0000_00A2;
      settle();
      chk("pkt_a2", out_data, 32'h0000_00A2);
      tick();
      req_valid = 4'b0000;
      settle();
      chk("pkt_drop_valid", out_valid, 0);
      chk("pkt_drop_busy", busy, 1);
      tick();
      chk("pkt_release_busy", busy, 0);
      chk("pkt_release_grant", grant, 0);
      req_valid = 4'b0100;
      tick();
      chk("pkt_regrant", grant, 4'b0100);

      // Receiver stall on requester 1
      req_valid = 4'b0000;
      do_reset();
      set_data();
      req_valid = 4'b0010;
      tick();
      chk("stall_grant", grant, 4'b0010);
      chk("stall_ready_pre", req_ready, 4'b0010);
      out_ready = 1'b0;
      settle();
      chk("stall_ready_low", req_ready, 0);
      chk("stall_valid", out_valid, 1);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall_hold_grant", grant, 4'b0010);
         chk("stall_hold_ready", req_ready, 0);
         chk("stall_hold_data", out_data, 32'hD000_0001);
      end
      req_data[1*DW +: DW] = 32'hBEEF_0001;
      settle();
      chk("stall_passthru", out_data, 32'hBEEF_0001);
      out_ready = 1'b1;
      settle();
      chk("stall_ready_back", req_ready, 4'b0010);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_beats", grant, 4'b0010);
      end
      tick();
      chk("stall_done", grant, 0);

      // Wrap-around from last_ptr=0 with requesters 0 and 3
      req_valid = 4'b0000;
      do_reset();
      set_data();
      req_valid = 4'b0001;
      tick();
      chk("wrap_setup", grant, 4'b0001);
      req_valid = 4'b0000;
      tick();
      chk("wrap_setup_rel", grant, 0);
      req_valid = 4'b1001;
      tick();
      chk("wrap_first", grant, 4'b1000);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("wrap_burst", grant, 4'b1000);
      end
      tick();
      chk("wrap_bubble", grant, 0);
      tick();
      chk("wrap_second", grant, 4'b0001);

      // Reset asserted mid-burst
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b0010;
      tick();
      chk("mid_grant", grant, 4'b0010);
      tick();
      tick();
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      req_valid = 4'b0011;
      @(posedge clk);
      #1;
      chk("mid_rst_hold", grant, 0);
      rst_n = 1'b1;
      tick();
      chk("mid_after_rst", grant, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_arbiter.md
RX_ARBITER -- requirements
Module: rx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter DW, default 32, data width per requester.
REQ-003 Parameter BURST_MAX, default 4, maximum beats per grant before forced rotation; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  NREQ  per-requester valid; bit i belongs to requester i.
REQ-007 req_data  in  NREQ*DW  requester i data at bits [DW*i+DW-1 : DW*i].
REQ-008 req_ready  out  NREQ  per-requester ready; at most one bit high.
REQ-009 out_valid  out  1  valid toward the shared receiver.
REQ-010 out_data  out  DW  data toward the shared receiver.
REQ-011 out_ready  in  1  ready from the shared receiver.
REQ-012 grant  out  NREQ  registered one-hot grant; all-zero when no requester is granted.
REQ-013 busy  out  1  high while in state GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE, if any req_valid bit is high, the FSM SHALL select the first requester with valid high, searching upward from (last_ptr+1) mod NREQ, and wrapping.
REQ-016 On the selecting edge, the FSM SHALL load grant, clear beat_cnt to 0 and move to GRANT; this gives a fixed one-cycle arbitration bubble.
REQ-017 In IDLE with no req_valid bit high, the FSM SHALL stay in IDLE with grant=0.
REQ-018 In GRANT with requester g granted:
  - out_valid = req_valid[g]
  - out_data = req_data slice g
  - req_ready[g] = out_ready
  - all other req_ready bits = 0
  These paths SHALL be combinational from the registered grant.
REQ-019 In IDLE:
  - out_valid = 0
  - out_data = 0
  - req_ready = 0
REQ-020 A beat SHALL be a cycle in GRANT with req_valid[g] & out_ready both high; each beat SHALL increment beat_cnt.
  - beat_cnt width = ceil(log2(BURST_MAX+1)).
  - beat_cnt SHALL never exceed BURST_MAX.
REQ-021 On a beat that brings beat_cnt to BURST_MAX, the FSM SHALL:
  - return to IDLE,
  - set last_ptr=g,
  - clear grant.
REQ-022 In a GRANT cycle where req_valid[g] is low, the FSM SHALL release in that cycle: return to IDLE, set last_ptr=g, clear grant.
REQ-023 In a GRANT cycle where req_valid[g] is high and out_ready is low, the FSM SHALL hold state, grant and beat_cnt unchanged.
REQ-024 Requests from non-granted requesters during GRANT SHALL NOT affect the current grant; they are considered only at the next IDLE cycle.
REQ-025 A requester that loses the grant and still has valid high SHALL be re-arbitrated normally under the rotation rule, with no special priority.
REQ-026 With only one requester active, it SHALL be re-granted after each release, with one bubble cycle between grants.
REQ-027 Changes of req_data on the granted requester while out_ready is low SHALL be passed through unchanged; the arbiter performs no buffering.
REQ-028 req_ready SHALL NOT depend on the requester's own req_valid.

Reset
REQ-029 While rst_n is low, the block SHALL hold:
  - state = IDLE
  - grant = 0
  - beat_cnt = 0
  - last_ptr = NREQ-1, so requester 0 wins first
  - busy = 0
  - out_valid = 0
  - out_data = 0
  - req_ready = 0
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately and asynchronously, with no beat counted in that cycle.
REQ-031 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge at which rst_n is sampled high.

Verification
REQ-032 Reset, then req_valid=4'b1111 held, out_ready=1, BURST_MAX=4 -> grant sequence 0001,0010,0100,1000,0001. Each grant carries 4 beats followed by 1 bubble cycle.
REQ-033 Only requester 2 valid, 3 words A0..A2, then valid drops; out_ready=1 -> out_data A0,A1,A2 on consecutive cycles, then release. When requester 2's valid drops, busy falls on the following edge.
REQ-034 Requester 1 granted, out_ready=0 for 5 cycles with valid high -> grant, beat_cnt and out_data stable, req_ready=0010 only when out_ready=1. The 4 beats complete after out_ready returns high.
REQ-035 Requesters 0 and 3 valid, last_ptr=0 -> requester 3 granted first, then requester 0 (wrap-around).
REQ-036 rst_n pulsed low after beat 2 of a 4-beat burst by requester 1 -> all outputs 0 asynchronously. After release of reset, with requesters 0 and 1 valid, requester 0 is granted first.
REQ-037 Bench SHALL check every cycle:
  - at most one req_ready bit high,
  - out_valid & out_ready implies exactly one req_ready bit high.
